// File: rtl/apb4_pkg.sv
// Shared types and decode constants for the APB4 completer front end.
package apb4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [9:0] REG_WIN_LAST_IDX = 10'd3;
    localparam logic [5:0] ID_WIN_TAG       = 6'h3F;
    localparam int         PROT_PRIV_BIT    = 0;

endpackage

// File: rtl/apb4_slave_if.sv
// APB4 completer front end: turns SETUP/ACCESS phases into single-cycle
// register strobes with wait states, decode/protection errors and registered responses.
module apb4_slave_if
    import apb4_pkg::*;
#(
    parameter int ADDRWIDTH   = 12,
    parameter int WAIT_STATES = 0,
    parameter bit PROT_CHECK  = 1'b0
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic [31:0]          pwdata,
    input  logic [3:0]           pstrb,
    input  logic [2:0]           pprot,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [ADDRWIDTH-1:0] addr,
    output logic                 read_en,
    output logic                 write_en,
    output logic [3:0]           byte_strobe,
    output logic [31:0]          wdata,
    input  logic [31:0]          rdata
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15 || ADDRWIDTH < 12) begin : g_bad_param
        $error("apb4_slave_if: WAIT_STATES must be 0..15 and ADDRWIDTH >= 12");
    end

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_e               state_q;
    logic [3:0]           cnt_q;
    logic                 dir_write_q;
    logic                 err_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           strb_q;
    logic [31:0]          prdata_q;
    logic                 pready_q;
    logic                 pslverr_q;

    logic [9:0] word_idx;
    logic       in_reg_win;
    logic       in_id_win;
    logic       decode_err;
    logic       prot_err;
    logic       setup;
    logic       strobe;
    logic [1:0] unused_prot;

    assign unused_prot = pprot[2:1];

    // Reads may also hit the ID window; writes only the register window.
    assign word_idx   = paddr[11:2];
    assign in_reg_win = (word_idx <= REG_WIN_LAST_IDX);
    assign in_id_win  = (paddr[11:6] == ID_WIN_TAG);
    assign decode_err = pwrite ? ~in_reg_win : ~(in_reg_win | in_id_win);
    assign prot_err   = PROT_CHECK & pwrite & ~pprot[PROT_PRIV_BIT];

    assign setup    = psel & ~penable;
    assign strobe   = (state_q == WAIT) & psel & (cnt_q == 4'd0);
    assign read_en  = strobe & ~dir_write_q;
    assign write_en = strobe & dir_write_q & ~err_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            dir_write_q <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            strb_q      <= 4'h0;
            prdata_q    <= 32'h0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        addr_q      <= paddr;
                        dir_write_q <= pwrite;
                        wdata_q     <= pwdata;
                        strb_q      <= pwrite ? pstrb : 4'h0;
                        err_q       <= decode_err | prot_err;
                        cnt_q       <= WAIT_INIT;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        prdata_q  <= (~dir_write_q & ~err_q) ? rdata : 32'h0;
                        pslverr_q <= err_q;
                        pready_q  <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    prdata_q  <= 32'h0;
                    pslverr_q <= 1'b0;
                    pready_q  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata      = prdata_q;
    assign pready      = pready_q;
    assign pslverr     = pslverr_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign byte_strobe = strb_q;

endmodule

// File: doc/apb4_slave_if.md
Name: apb4_slave_if

Overview:
- APB4 completer-side protocol front end.
- Sits directly upstream of the 32-bit slave register block and drives its simple register interface (addr, read_en, write_en, byte_strobe, wdata, rdata).
- Converts APB4 SETUP/ACCESS phases into single-cycle register strobes, with programmable wait states, address-decode and protection error reporting, and registered pready/prdata/pslverr.

Parameters:
- ADDRWIDTH, 12, width of paddr and addr. Decode below uses bits [11:2].
- WAIT_STATES, 0, extra access-phase cycles before the strobe. Legal range 0..15.
- PROT_CHECK, 0, when 1, a write with pprot[0]=0 (unprivileged) is rejected with pslverr.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset, asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write.
- paddr  in  ADDRWIDTH  byte address.
- pwdata  in  32  write data.
- pstrb  in  4  write byte lanes.
- pprot  in  3  protection attributes.
- prdata  out  32  read data, registered.
- pready  out  1  transfer complete, registered.
- pslverr  out  1  transfer error, registered.
- addr  out  ADDRWIDTH  register address, latched in SETUP.
- read_en  out  1  read strobe, combinational from state.
- write_en  out  1  write strobe, combinational from state.
- byte_strobe  out  4  latched pstrb. Forced to 0 on reads.
- wdata  out  32  latched pwdata.
- rdata  in  32  combinational read data from the register block.

Behaviour:
- Reset (async, presetn=0): state IDLE; prdata=0, pready=0, pslverr=0, addr=0, wdata=0, byte_strobe=0, cnt=0. read_en and write_en are 0.
- Reset mid-transfer: the transfer is abandoned and no strobe is issued after reset is applied.

State machine: IDLE, WAIT, DONE.
- IDLE:
  - On psel=1 and penable=0 (SETUP), latch paddr, pwrite, pwdata, pstrb (0 if read).
  - Latch err = decode_err | prot_err.
  - Load cnt=WAIT_STATES, then go to WAIT.
  - psel=1 with penable=1 while in IDLE is ignored.
- WAIT:
  - If psel=0, abort: go to IDLE with no strobe and pready stays 0.
  - Else if cnt!=0, decrement cnt.
  - Else (cnt==0), this is the strobe cycle:
    - read_en = ~dir_write.
    - write_en = dir_write & ~err.
    - prdata <= (read & ~err) ? rdata : 0.
    - pslverr <= err, pready <= 1, go to DONE.
- DONE:
  - pready=1 is visible and the transfer completes at this edge.
  - Next state is IDLE. pready, pslverr and prdata are cleared to 0.
  - Back-to-back: a SETUP in the following cycle is accepted normally.

Timing and decode:
- Latency: SETUP at cycle T0, strobe at T1+WAIT_STATES, pready=1 at T2+WAIT_STATES. The access phase lasts WAIT_STATES+2 cycles, so the minimum is 1 wait state.
- read_en and write_en are each high for exactly one cycle per transfer and are never high together.
- decode_err is computed from paddr[11:2]:
  - Read legal if word index is 0..3 (0x000–0x00C), or paddr[11:6]=6'h3F (0xFC0–0xFFC).
  - Write legal only for word index 0..3.
  - Anything else gives decode_err=1.
- prot_err = PROT_CHECK & pwrite & ~pprot[0].
- Error reads return prdata=0. Error writes suppress write_en.
- pslverr is 0 whenever pready is 0.
- paddr[1:0] is ignored. pstrb=0 on a write still issues write_en with byte_strobe=0, so no bytes change and this is not an error.
- Wait counter is 4 bits and does not wrap. WAIT_STATES>15 is a compile-time error.

Decomposition:
- Shared package apb4_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - REG_WIN_LAST_IDX=10'd3;
  - ID_WIN_TAG=6'h3F;
  - PROT_PRIV_BIT=0.
- No sub-module. FSM, counter and decode are inline.

Test Plan:
- Write paddr=0x004, pwdata=0xDEADBEEF, pstrb=4'hF, WAIT_STATES=0 -> write_en high 1 cycle at T1 with addr=0x004; pready=1 at T2, pslverr=0; a following read of 0x004 returns prdata=0xDEADBEEF.
- Read paddr=0xFE0 with rdata driven 0x19, WAIT_STATES=3 -> read_en only at T4, pready at T5, prdata=0x00000019, no earlier pready.
- Write paddr=0x010 -> write_en never high, pready=1 with pslverr=1. Read paddr=0x100 -> pslverr=1, prdata=0.
- PROT_CHECK=1, write 0x000 with pprot=3'b000 -> pslverr=1, no write_en. Same write with pprot=3'b001 -> write_en=1, pslverr=0.
- Back-to-back write 0x008 then read 0x008 with no idle cycle -> both complete, with 2 separate strobes and pready pulses one per transfer.
- presetn low during WAIT (WAIT_STATES=5) -> outputs 0 immediately, no strobe; next transfer after reset completes normally.
